// File: rtl/ofs_asp_pkg.sv
// ----------------------------------------------------------------------------
// ofs_asp_pkg
//   Shared constants and helpers for the USM host-memory AVMM path.
//   ASP_HOST_PAGE_BYTES     host page size; host transactions never straddle it
//   ASP_USM_*               default widths of the USM AVMM interface
//   asp_words_to_page_end   words from a word address up to the next page
//                           boundary (1..page_words)
// ----------------------------------------------------------------------------
package ofs_asp_pkg;

    localparam int ASP_HOST_PAGE_BYTES     = 4096;
    localparam int ASP_USM_ADDR_WIDTH      = 26;
    localparam int ASP_USM_DATA_WIDTH      = 512;
    localparam int ASP_USM_BURSTCOUNT_WIDTH = 5;

    // Wide enough for any BURSTCOUNT_WIDTH + log2(PAGE_WORDS) in use on this
    // path; callers cast the result down to their own counter width.
    localparam int ASP_TO_END_W = 32;

    // page_words must be a power of two. Only the low address bits matter,
    // so the top-of-space wrap is naturally treated as a page boundary.
    function automatic logic [ASP_TO_END_W-1:0] asp_words_to_page_end(
        input logic [31:0] addr,
        input logic [31:0] page_words
    );
        logic [31:0] off;
        off = addr & (page_words - 32'd1);
        return page_words - off;
    endfunction

endpackage

// File: rtl/avmm_page_boundary_burst_split.sv
// ----------------------------------------------------------------------------
// avmm_page_boundary_burst_split
//   Splits AVMM read/write bursts that cross a PAGE_BYTES boundary into
//   page-contained sub-bursts with zero added latency. Write beats pass through
//   one-for-one (address/burstcount overridden inside a split); a crossing read
//   becomes one sink command per page while the source read is held with
//   waitrequest until the final chunk is accepted. Read data passes straight
//   through.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ST_IDLE     | waiting for a burst start; non-crossing reads pass through
//   ST_WR_BURST | forwarding remaining write beats, opening sub-bursts at pages
//   ST_RD_SPLIT | issuing the remaining page-sized read commands
//
//   Ports
//   clk, reset_n                 clock, async active-low reset
//   src_*                        upstream AVMM slave side
//   snk_*                        downstream AVMM master side
// ----------------------------------------------------------------------------
module avmm_page_boundary_burst_split
    import ofs_asp_pkg::*;
#(
    parameter int ADDR_WIDTH       = ASP_USM_ADDR_WIDTH,
    parameter int DATA_WIDTH       = ASP_USM_DATA_WIDTH,
    parameter int BURSTCOUNT_WIDTH = ASP_USM_BURSTCOUNT_WIDTH,
    parameter int PAGE_BYTES       = ASP_HOST_PAGE_BYTES
) (
    input  logic                        clk,
    input  logic                        reset_n,

    input  logic [ADDR_WIDTH-1:0]       src_address,
    input  logic [BURSTCOUNT_WIDTH-1:0] src_burstcount,
    input  logic                        src_read,
    input  logic                        src_write,
    input  logic [DATA_WIDTH-1:0]       src_writedata,
    input  logic [DATA_WIDTH/8-1:0]     src_byteenable,
    output logic                        src_waitrequest,
    output logic [DATA_WIDTH-1:0]       src_readdata,
    output logic                        src_readdatavalid,

    output logic [ADDR_WIDTH-1:0]       snk_address,
    output logic [BURSTCOUNT_WIDTH-1:0] snk_burstcount,
    output logic                        snk_read,
    output logic                        snk_write,
    output logic [DATA_WIDTH-1:0]       snk_writedata,
    output logic [DATA_WIDTH/8-1:0]     snk_byteenable,
    input  logic                        snk_waitrequest,
    input  logic [DATA_WIDTH-1:0]       snk_readdata,
    input  logic                        snk_readdatavalid
);

    localparam int PAGE_WORDS = PAGE_BYTES / (DATA_WIDTH / 8);
    localparam int PW_LOG2    = $clog2(PAGE_WORDS);
    localparam int CNT_W      = BURSTCOUNT_WIDTH + PW_LOG2;

    localparam logic [CNT_W-1:0]            PW_C = CNT_W'(PAGE_WORDS);
    // Only used when beats_left > PAGE_WORDS, so PAGE_WORDS fits the count.
    localparam logic [BURSTCOUNT_WIDTH-1:0] PW_B = BURSTCOUNT_WIDTH'(PAGE_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_SPLIT
    } state_e;

    state_e                        state;
    logic [BURSTCOUNT_WIDTH-1:0]   total_left;   // beats (wr) or words (rd) still to issue
    logic [BURSTCOUNT_WIDTH-1:0]   sub_left;     // beats left in current write sub-burst
    logic [BURSTCOUNT_WIDTH-1:0]   sub_bcnt;     // held burstcount of current sub-burst
    logic [ADDR_WIDTH-1:0]         sub_addr;     // held start address of current sub-burst
    logic [ADDR_WIDTH-1:0]         next_addr;    // start of the next page-aligned chunk

    logic [CNT_W-1:0]              to_end;
    logic [CNT_W-1:0]              bcnt_ext;
    logic [CNT_W-1:0]              left_ext;
    logic                          crossing;
    logic [BURSTCOUNT_WIDTH-1:0]   first_cnt;
    logic [BURSTCOUNT_WIDTH-1:0]   chunk_cnt;
    logic                          rd_final;

    assign to_end    = CNT_W'(asp_words_to_page_end(32'(src_address), 32'(PAGE_WORDS)));
    assign bcnt_ext  = CNT_W'(src_burstcount);
    assign crossing  = (bcnt_ext > to_end);
    // When crossing, to_end < burstcount so it fits the burstcount width.
    assign first_cnt = crossing ? to_end[BURSTCOUNT_WIDTH-1:0] : src_burstcount;

    assign left_ext  = CNT_W'(total_left);
    assign chunk_cnt = (left_ext > PW_C) ? PW_B : total_left;
    assign rd_final  = (left_ext <= PW_C);

    assign snk_writedata     = src_writedata;
    assign snk_byteenable    = src_byteenable;
    assign src_readdata      = snk_readdata;
    assign src_readdatavalid = snk_readdatavalid;

    always_comb begin
        snk_address     = src_address;
        snk_burstcount  = first_cnt;
        snk_read        = 1'b0;
        snk_write       = 1'b0;
        src_waitrequest = snk_waitrequest;
        unique case (state)
            ST_IDLE: begin
                snk_read  = src_read;
                snk_write = src_write;
                // Hold the source read until the last page chunk goes out.
                if (src_read && crossing) begin
                    src_waitrequest = 1'b1;
                end
            end
            ST_WR_BURST: begin
                snk_write = src_write;
                if (sub_left == '0) begin
                    snk_address    = next_addr;
                    snk_burstcount = chunk_cnt;
                end else begin
                    snk_address    = sub_addr;
                    snk_burstcount = sub_bcnt;
                end
            end
            ST_RD_SPLIT: begin
                snk_read       = src_read;
                snk_address    = next_addr;
                snk_burstcount = chunk_cnt;
                if (!rd_final) begin
                    src_waitrequest = 1'b1;
                end
            end
            default: ;
        endcase
        // Quiet the sink immediately on reset, not only after the next edge.
        if (!reset_n) begin
            snk_read        = 1'b0;
            snk_write       = 1'b0;
            src_waitrequest = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            total_left <= '0;
            sub_left   <= '0;
            sub_bcnt   <= '0;
            sub_addr   <= '0;
            next_addr  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (src_write && !snk_waitrequest &&
                        src_burstcount != BURSTCOUNT_WIDTH'(1)) begin
                        state      <= ST_WR_BURST;
                        total_left <= src_burstcount - 1'b1;
                        sub_left   <= first_cnt - 1'b1;
                        sub_bcnt   <= first_cnt;
                        sub_addr   <= src_address;
                        next_addr  <= src_address + ADDR_WIDTH'(first_cnt);
                    end else if (src_read && crossing && !snk_waitrequest) begin
                        state      <= ST_RD_SPLIT;
                        total_left <= src_burstcount - first_cnt;
                        next_addr  <= src_address + ADDR_WIDTH'(first_cnt);
                    end
                end
                ST_WR_BURST: begin
                    if (src_write && !snk_waitrequest) begin
                        if (sub_left == '0) begin
                            sub_left  <= chunk_cnt - 1'b1;
                            sub_bcnt  <= chunk_cnt;
                            sub_addr  <= next_addr;
                            next_addr <= next_addr + ADDR_WIDTH'(chunk_cnt);
                        end else begin
                            sub_left  <= sub_left - 1'b1;
                        end
                        total_left <= total_left - 1'b1;
                        if (total_left == BURSTCOUNT_WIDTH'(1)) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RD_SPLIT: begin
                    if (src_read && !snk_waitrequest) begin
                        if (rd_final) begin
                            state <= ST_IDLE;
                        end else begin
                            total_left <= total_left - PW_B;
                            next_addr  <= next_addr + ADDR_WIDTH'(PAGE_WORDS);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    a_no_rd_and_wr: assert property (@(posedge clk) disable iff (!reset_n)
        !(src_read && src_write));

    a_nonzero_bcnt: assert property (@(posedge clk) disable iff (!reset_n)
        (state == ST_IDLE && (src_read || src_write)) |-> (src_burstcount != '0));

endmodule

// File: tb/tb_avmm_page_boundary_burst_split.sv
module tb_avmm_page_boundary_burst_split;

    localparam int AW  = 26;
    localparam int DW  = 512;
    localparam int BW  = 5;
    localparam int PW  = 64;
    localparam int PWL = 6;

    logic          clk;
    logic          reset_n;
    logic [AW-1:0] src_address;
    logic [BW-1:0] src_burstcount;
    logic          src_read;
    logic          src_write;
    logic [DW-1:0] src_writedata;
    logic [DW/8-1:0] src_byteenable;
    logic          src_waitrequest;
    logic [DW-1:0] src_readdata;
    logic          src_readdatavalid;
    logic [AW-1:0] snk_address;
    logic [BW-1:0] snk_burstcount;
    logic          snk_read;
    logic          snk_write;
    logic [DW-1:0] snk_writedata;
    logic [DW/8-1:0] snk_byteenable;
    logic          snk_waitrequest;
    logic [DW-1:0] snk_readdata;
    logic          snk_readdatavalid;

    avmm_page_boundary_burst_split #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BW), .PAGE_BYTES(4096)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .src_address(src_address), .src_burstcount(src_burstcount),
        .src_read(src_read), .src_write(src_write),
        .src_writedata(src_writedata), .src_byteenable(src_byteenable),
        .src_waitrequest(src_waitrequest), .src_readdata(src_readdata),
        .src_readdatavalid(src_readdatavalid),
        .snk_address(snk_address), .snk_burstcount(snk_burstcount),
        .snk_read(snk_read), .snk_write(snk_write),
        .snk_writedata(snk_writedata), .snk_byteenable(snk_byteenable),
        .snk_waitrequest(snk_waitrequest), .snk_readdata(snk_readdata),
        .snk_readdatavalid(snk_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [BW-1:0]   bcnt;
        logic [DW-1:0]   data;
        logic [DW/8-1:0] be;
    } wr_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [BW-1:0] bcnt;
    } rd_exp_t;

    wr_exp_t       exp_wr[$];
    rd_exp_t       exp_rd[$];
    logic [AW-1:0] ch_a[$];
    int            ch_n[$];

    int vectors     = 0;
    int miscompares = 0;
    int wr_beats    = 0;
    bit rand_wait   = 1'b0;
    bit mirror_en   = 1'b0;

    // Reference split: walk the burst page by page.
    task automatic model_split(input logic [AW-1:0] a, input int n);
        logic [AW-1:0] cur;
        int left, off, c;
        ch_a.delete();
        ch_n.delete();
        cur  = a;
        left = n;
        while (left > 0) begin
            off = int'(cur[PWL-1:0]);
            c   = PW - off;
            if (c > left) c = left;
            ch_a.push_back(cur);
            ch_n.push_back(c);
            cur  = cur + AW'(c);
            left = left - c;
        end
    endtask

    // Downstream waitrequest generator.
    initial begin
        snk_waitrequest = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            snk_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Sink-side monitor / scoreboard consumer.
    initial begin
        forever begin
            @(negedge clk);
            if (mirror_en && src_write) begin
                vectors++;
                if (src_waitrequest !== snk_waitrequest) begin
                    miscompares++;
                    $display("FAIL wr_wait_mirror: src_waitrequest=%b snk_waitrequest=%b", src_waitrequest, snk_waitrequest);
                end
            end
            if (snk_write && !snk_waitrequest) begin
                wr_beats++;
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_extra_beat: got addr %h bcnt %0d, expected no beat", snk_address, snk_burstcount);
                end else begin
                    wr_exp_t e;
                    e = exp_wr.pop_front();
                    if (snk_address !== e.addr || snk_burstcount !== e.bcnt) begin
                        miscompares++;
                        $display("FAIL wr_cmd: got (%h,%0d) want (%h,%0d)", snk_address, snk_burstcount, e.addr, e.bcnt);
                    end
                    vectors++;
                    if (snk_writedata !== e.data || snk_byteenable !== e.be) begin
                        miscompares++;
                        $display("FAIL wr_data: got be %h want be %h data %h want %h", snk_byteenable, e.be, snk_writedata[63:0], e.data[63:0]);
                    end
                end
            end
            if (snk_read && !snk_waitrequest) begin
                vectors++;
                if (exp_rd.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_extra_cmd: got (%h,%0d), expected no command", snk_address, snk_burstcount);
                end else begin
                    rd_exp_t e;
                    logic    want_wait;
                    want_wait = (exp_rd.size() > 1);
                    e = exp_rd.pop_front();
                    if (snk_address !== e.addr || snk_burstcount !== e.bcnt) begin
                        miscompares++;
                        $display("FAIL rd_cmd: got (%h,%0d) want (%h,%0d)", snk_address, snk_burstcount, e.addr, e.bcnt);
                    end
                    vectors++;
                    if (src_waitrequest !== want_wait) begin
                        miscompares++;
                        $display("FAIL rd_src_wait: got %b want %b", src_waitrequest, want_wait);
                    end
                end
            end
        end
    end

    task automatic drive_write(input logic [AW-1:0] addr, input int n);
        logic [DW-1:0]   d[$];
        logic [DW/8-1:0] e[$];
        wr_exp_t         x;
        int              b, guard;
        bit              acc;
        model_split(addr, n);
        for (int k = 0; k < ch_a.size(); k++) begin
            for (int j = 0; j < ch_n[k]; j++) begin
                x.addr = ch_a[k];
                x.bcnt = BW'(ch_n[k]);
                x.data = {16{$urandom}};
                x.be   = {$urandom, $urandom};
                d.push_back(x.data);
                e.push_back(x.be);
                exp_wr.push_back(x);
            end
        end
        src_address    = addr;
        src_burstcount = BW'(n);
        src_write      = 1'b1;
        b     = 0;
        guard = 0;
        while (b < n && guard < 2000) begin
            src_writedata  = d[b];
            src_byteenable = e[b];
            @(negedge clk);
            acc = !src_waitrequest;
            @(posedge clk);
            #1;
            if (acc) b++;
            guard++;
        end
        src_write = 1'b0;
        vectors++;
        if (b != n) begin
            miscompares++;
            $display("FAIL wr_timeout: accepted %0d beats want %0d", b, n);
        end
    endtask

    task automatic drive_read(input logic [AW-1:0] addr, input int n);
        rd_exp_t x;
        int      guard;
        bit      acc;
        model_split(addr, n);
        for (int k = 0; k < ch_a.size(); k++) begin
            x.addr = ch_a[k];
            x.bcnt = BW'(ch_n[k]);
            exp_rd.push_back(x);
        end
        src_address    = addr;
        src_burstcount = BW'(n);
        src_read       = 1'b1;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 2000) begin
            @(negedge clk);
            acc = !src_waitrequest;
            @(posedge clk);
            #1;
            guard++;
        end
        src_read = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("FAIL rd_timeout: source read never accepted");
        end
        vectors++;
        if (exp_rd.size() != 0) begin
            miscompares++;
            $display("FAIL rd_cmds_left: %0d sink commands outstanding at source accept, want 0", exp_rd.size());
        end
    endtask

    task automatic check_wr_done(input string name, input int want_beats);
        vectors++;
        if (exp_wr.size() != 0 || wr_beats != want_beats) begin
            miscompares++;
            $display("FAIL %s: sink beats %0d pending %0d, want %0d beats 0 pending", name, wr_beats, exp_wr.size(), want_beats);
        end
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        src_address    = '0;
        src_burstcount = BW'(4);
        src_read       = 1'b0;
        src_write      = 1'b1;
        src_writedata  = '0;
        src_byteenable = '1;
        snk_readdata   = '0;
        snk_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (snk_write !== 1'b0 || snk_read !== 1'b0 || src_waitrequest !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: snk_write=%b snk_read=%b src_wait=%b want 0 0 1", snk_write, snk_read, src_waitrequest);
        end
        src_write = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_cross_write;
        rand_wait = 1'b1;
        mirror_en = 1'b1;
        wr_beats  = 0;
        drive_write(AW'(32'h30), 16);
        check_wr_done("no_cross_write", 16);
    endtask

    task automatic test_cross_write;
        rand_wait = 1'b0;
        wr_beats  = 0;
        drive_write(AW'(32'h38), 16);
        check_wr_done("cross_write", 16);
    endtask

    task automatic test_cross_read;
        logic [DW-1:0] pat;
        rand_wait = 1'b1;
        mirror_en = 1'b0;
        drive_read(AW'(32'h7C), 16);
        rand_wait = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pat = {16{32'hC0DE0000 + 32'(i)}};
            snk_readdata      = pat;
            snk_readdatavalid = 1'b1;
            @(negedge clk);
            vectors++;
            if (src_readdatavalid !== 1'b1 || src_readdata !== pat) begin
                miscompares++;
                $display("FAIL readdata_%0d: valid %b data %h want 1 %h", i, src_readdatavalid, src_readdata[31:0], pat[31:0]);
            end
            @(posedge clk);
            #1;
        end
        snk_readdatavalid = 1'b0;
        @(negedge clk);
        vectors++;
        if (src_readdatavalid !== 1'b0) begin
            miscompares++;
            $display("FAIL readdata_idle: valid %b want 0", src_readdatavalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cross_write_random_wait;
        rand_wait = 1'b1;
        mirror_en = 1'b1;
        wr_beats  = 0;
        drive_write(AW'(32'h38), 16);
        check_wr_done("cross_write_rand", 16);
        rand_wait = 1'b0;
        mirror_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst;
        wr_exp_t x;
        rand_wait = 1'b0;
        @(posedge clk);
        #1;
        wr_beats       = 0;
        src_address    = AW'(32'h38);
        src_burstcount = BW'(16);
        src_write      = 1'b1;
        for (int b = 0; b < 5; b++) begin
            x.addr = AW'(32'h38);
            x.bcnt = BW'(8);
            x.data = {16{$urandom}};
            x.be   = {$urandom, $urandom};
            exp_wr.push_back(x);
            src_writedata  = x.data;
            src_byteenable = x.be;
            @(posedge clk);
            #1;
        end
        src_writedata = {16{32'hDEADBEEF}};
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (snk_write !== 1'b0 || snk_read !== 1'b0 || src_waitrequest !== 1'b1) begin
            miscompares++;
            $display("FAIL midburst_reset: snk_write=%b snk_read=%b src_wait=%b want 0 0 1", snk_write, snk_read, src_waitrequest);
        end
        src_write = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_wr_done("pre_reset_beats", 5);
        @(posedge clk);
        #1;
        wr_beats = 0;
        drive_write(AW'(32'h3F), 2);
        check_wr_done("post_reset_write", 2);
    endtask

    task automatic test_top_wrap_read;
        logic [AW-1:0] top;
        top = '1;
        top = top - AW'(3);
        rand_wait = 1'b0;
        drive_read(top, 8);
        rand_wait = 1'b1;
        drive_read(AW'(32'h100), 4);
        rand_wait = 1'b0;
    endtask

    task automatic test_back_to_back;
        rand_wait = 1'b1;
        mirror_en = 1'b1;
        wr_beats  = 0;
        drive_write(AW'(32'h3F), 1);
        drive_write(AW'(32'h7E), 16);
        drive_write(AW'(32'hC0), 16);
        check_wr_done("back_to_back", 33);
        mirror_en = 1'b0;
        drive_read(AW'(32'hBF), 2);
        rand_wait = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_cross_write();
        test_cross_write();
        test_cross_read();
        test_cross_write_random_wait();
        test_reset_mid_burst();
        test_top_wrap_read();
        test_back_to_back();
        repeat (4) @(posedge clk);
        vectors++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            miscompares++;
            $display("FAIL final_queues: wr %0d rd %0d pending, want 0 0", exp_wr.size(), exp_rd.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
